// File: rtl/addend_align.sv
// Addend significand alignment for the single-precision FMA datapath.
// Two-stage valid/ready pipeline: shift computation, then 98-bit window alignment.
module addend_align #(
  parameter int BIAS   = 127,
  parameter int GUARD  = 27,
  parameter int MAX_SH = 74
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_exp,
  input  logic [7:0]  b_exp,
  input  logic [7:0]  c_exp,
  input  logic [23:0] c_frac,
  input  logic        eff_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [73:0] c_frac_align_h,
  output logic [23:0] c_frac_align_l,
  output logic        inv_mask,
  output logic        c_dominant,
  output logic [9:0]  prod_exp
);

  localparam int ALIGN_K = BIAS - GUARD;
  localparam logic signed [10:0] ALIGN_K_S = 11'(ALIGN_K);
  localparam logic signed [10:0] MAX_SH_S  = 11'(MAX_SH);

  // Exponent difference widened to 11 bits so the 8-bit sums cannot wrap.
  function automatic logic signed [10:0] calc_diff(input logic [7:0] a,
                                                   input logic [7:0] b,
                                                   input logic [7:0] c);
    logic signed [10:0] sum_v;
    sum_v = $signed({3'b000, a}) + $signed({3'b000, b}) - $signed({3'b000, c});
    return sum_v - ALIGN_K_S;
  endfunction

  function automatic logic [6:0] clamp_shift(input logic signed [10:0] d);
    logic [6:0] sh_v;
    if (d <= 11'sd0) begin
      sh_v = 7'd0;
    end else if (d >= MAX_SH_S) begin
      sh_v = 7'(MAX_SH);
    end else begin
      sh_v = d[6:0];
    end
    return sh_v;
  endfunction

  logic signed [10:0] d_s;
  logic [6:0]         sh_s;
  logic               dom_s;
  logic [9:0]         pexp_s;
  logic               en1_s;
  logic               en2_s;

  logic               s1_valid_r;
  logic [6:0]         s1_sh_r;
  logic [23:0]        s1_frac_r;
  logic               s1_inv_r;
  logic               s1_dom_r;
  logic [9:0]         s1_pexp_r;

  logic [97:0]        win_s;
  logic [73:0]        h_s;
  logic [23:0]        l_s;

  logic               out_valid_r;
  logic [73:0]        h_r;
  logic [23:0]        l_r;
  logic               inv_r;
  logic               dom_r;
  logic [9:0]         pexp_r;

  assign en2_s    = !out_valid_r || out_ready;
  assign en1_s    = !s1_valid_r || en2_s;
  assign in_ready = en1_s;

  assign d_s    = calc_diff(a_exp, b_exp, c_exp);
  assign sh_s   = clamp_shift(d_s);
  assign dom_s  = (d_s <= 11'sd0);
  assign pexp_s = {2'b00, a_exp} + {2'b00, b_exp} - 10'(ALIGN_K);

  // Alignment window and optional inversion for effective subtraction.
  always_comb begin
    win_s = {s1_frac_r, 74'd0} >> s1_sh_r;
    if (s1_inv_r) begin
      h_s = ~win_s[97:24];
      l_s = ~win_s[23:0];
    end else begin
      h_s = win_s[97:24];
      l_s = win_s[23:0];
    end
  end

  // Stage 1: shift amount, operand capture and valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sh_r    <= 7'd0;
      s1_frac_r  <= 24'd0;
      s1_inv_r   <= 1'b0;
      s1_dom_r   <= 1'b0;
      s1_pexp_r  <= 10'd0;
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (en1_s) begin
        s1_valid_r <= in_valid;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (en1_s) begin
        s1_sh_r   <= sh_s;
        s1_frac_r <= c_frac;
        s1_inv_r  <= eff_sub;
        s1_dom_r  <= dom_s;
        s1_pexp_r <= pexp_s;
      end
    end
  end

  // Stage 2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      h_r         <= 74'd0;
      l_r         <= 24'd0;
      inv_r       <= 1'b0;
      dom_r       <= 1'b0;
      pexp_r      <= 10'd0;
    end else begin
      if (flush) begin
        out_valid_r <= 1'b0;
      end else if (en2_s) begin
        out_valid_r <= s1_valid_r;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (en2_s) begin
        h_r    <= h_s;
        l_r    <= l_s;
        inv_r  <= s1_inv_r;
        dom_r  <= s1_dom_r;
        pexp_r <= s1_pexp_r;
      end
    end
  end

  assign out_valid      = out_valid_r;
  assign c_frac_align_h = h_r;
  assign c_frac_align_l = l_r;
  assign inv_mask       = inv_r;
  assign c_dominant     = dom_r;
  assign prod_exp       = pexp_r;

endmodule

// File: tb/tb_addend_align.sv
// Self-checking bench for addend_align: directed cases, stall/flush/reset and random traffic
// against a scoreboard of arithmetically computed expected results.
module tb_addend_align;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, eff_sub, out_valid, out_ready;
  logic [7:0]  a_exp, b_exp, c_exp;
  logic [23:0] c_frac;
  logic [73:0] c_frac_align_h;
  logic [23:0] c_frac_align_l;
  logic        inv_mask, c_dominant;
  logic [9:0]  prod_exp;

  addend_align dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .b_exp(b_exp), .c_exp(c_exp), .c_frac(c_frac), .eff_sub(eff_sub),
    .out_valid(out_valid), .out_ready(out_ready), .c_frac_align_h(c_frac_align_h),
    .c_frac_align_l(c_frac_align_l), .inv_mask(inv_mask), .c_dominant(c_dominant),
    .prod_exp(prod_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [109:0] r;
    int           t;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_deliv  = 0;
  bit   acc;

  // Expected result from the exponent rules: C placed at 2^(74-shift) in a 98-bit window.
  function automatic logic [109:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [23:0] f,
                                         input logic s);
    int          d;
    int          sh;
    logic [97:0] v;
    logic [73:0] h;
    logic [23:0] l;
    logic [9:0]  pe;
    d  = int'(a) + int'(b) - int'(c) - 100;
    sh = (d <= 0) ? 0 : ((d >= 74) ? 74 : d);
    v  = 98'(f) << (74 - sh);
    h  = v[97:24];
    l  = v[23:0];
    if (s) begin
      h = h ^ {74{1'b1}};
      l = l ^ {24{1'b1}};
    end
    pe = 10'(int'(a) + int'(b) - 100);
    return {h, l, s, (d <= 0), pe};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock: check at negedge, update scoreboard, advance past the posedge.
  task tick();
    logic [109:0] obs_v;
    @(negedge clk);
    obs_v = {c_frac_align_h, c_frac_align_l, inv_mask, c_dominant, prod_exp};
    chk("in_ready", 128'(in_ready), 128'((q.size() < 2) || out_ready));
    chk("out_valid", 128'(out_valid), 128'((q.size() > 0) && ((cyc - q[0].t) >= 2)));
    if (out_valid && q.size() > 0) chk("payload", 128'(obs_v), 128'(q[0].r));
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      n_deliv++;
    end
    acc = in_valid && in_ready;
    if (flush) q.delete();
    else if (acc) q.push_back('{model(a_exp, b_exp, c_exp, c_frac, eff_sub), cyc});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [23:0] f, input logic s);
    a_exp = a; b_exp = b; c_exp = c; c_frac = f; eff_sub = s;
  endtask

  task automatic rand_op();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    if ($urandom_range(0, 1) == 0)
      set_op(a, b, 8'($urandom), 24'($urandom) | 24'h800000, 1'($urandom));
    else
      set_op(a, b, 8'(int'(a) + int'(b) - 100 - int'($urandom_range(0, 90))),
             24'($urandom) | 24'h800000, 1'($urandom));
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [23:0] f, input logic s,
                          input logic [73:0] eh, input logic [23:0] el, input logic ed,
                          input logic [9:0] ep);
    set_op(a, b, c, f, s);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_h"}, 128'(c_frac_align_h), 128'(eh));
    chk({tag, "_l"}, 128'(c_frac_align_l), 128'(el));
    chk({tag, "_inv"}, 128'(inv_mask), 128'(s));
    chk({tag, "_dom"}, 128'(c_dominant), 128'(ed));
    chk({tag, "_pexp"}, 128'(prod_exp), 128'(ep));
    tick();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk({tag, "_drained"}, 128'(q.size()), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, deliv0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(8'd0, 8'd0, 8'd0, 24'd0, 1'b0);
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'({c_frac_align_h, c_frac_align_l, inv_mask, c_dominant, prod_exp}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

    directed("t1", 8'd127, 8'd127, 8'd127, 24'h800000, 1'b0,
             74'h1 << 46, 24'h000000, 1'b0, 10'd154);
    directed("t2", 8'd127, 8'd127, 8'd127, 24'h800000, 1'b1,
             ~(74'h1 << 46), 24'hFFFFFF, 1'b0, 10'd154);
    directed("t3", 8'd200, 8'd200, 8'd10, 24'hC00001, 1'b0,
             74'd0, 24'hC00001, 1'b0, 10'd300);
    directed("t3s", 8'd200, 8'd200, 8'd10, 24'hC00001, 1'b1,
             {74{1'b1}}, 24'h3FFFFE, 1'b0, 10'd300);
    directed("t4", 8'd100, 8'd100, 8'd200, 24'hABCDEF, 1'b0,
             {24'hABCDEF, 50'd0}, 24'd0, 1'b1, 10'd100);
    directed("t5", 8'd127, 8'd127, 8'd94, 24'hFFFFFF, 1'b0,
             74'h3FFF, 24'hFFC000, 1'b0, 10'd154);
    directed("d0", 8'd127, 8'd127, 8'd154, 24'h800001, 1'b0,
             {24'h800001, 50'd0}, 24'd0, 1'b1, 10'd154);
    directed("d74", 8'd127, 8'd127, 8'd80, 24'h812345, 1'b0,
             74'd0, 24'h812345, 1'b0, 10'd154);
    directed("dneg", 8'd0, 8'd0, 8'd255, 24'h900000, 1'b0,
             {24'h900000, 50'd0}, 24'd0, 1'b1, 10'h39C);

    // Four back-to-back ops with the consumer stalled for the first three cycles.
    sent = 0;
    deliv0 = n_deliv;
    for (int i = 0; i < 12; i++) begin
      out_ready = (i >= 3);
      in_valid  = (sent < 4);
      if (i == 0 || acc) rand_op();
      if (i == 2) begin
        #1;
        chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
        chk("stall_accepted", 128'(sent), 128'(2));
      end
      tick();
      if (acc) sent++;
    end
    drain("stall");
    chk("stall_delivered", 128'(n_deliv - deliv0), 128'(4));

    // Flush mid-stream, colliding with an input transfer.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_op();
      tick();
    end
    rand_op();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    tick();
    tick();

    // Asynchronous reset while results are in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      rand_op();
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_data", 128'({c_frac_align_h, c_frac_align_l, inv_mask, c_dominant, prod_exp}), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rand_op();
      tick();
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
